// File: rtl/tt_input_conditioner_if.sv
// rtl/tt_input_conditioner_if.sv - pad-side / core-side signal bundle for tt_input_conditioner
// evt_count and evt_clear exist only when EVT_COUNT_EN is defined.
interface tt_input_conditioner_if #(
   parameter int WIDTH = 8
);
   logic             ena;
   logic [WIDTH-1:0] raw_in;
   logic [WIDTH-1:0] clean_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic             any_change;
`ifdef EVT_COUNT_EN
   logic [7:0]       evt_count;
   logic             evt_clear;
`endif

   modport master (
`ifdef EVT_COUNT_EN
      output evt_clear,
      input  evt_count,
`endif
      output ena,
      output raw_in,
      input  clean_out,
      input  rise_pulse,
      input  fall_pulse,
      input  any_change
   );

   modport slave (
`ifdef EVT_COUNT_EN
      input  evt_clear,
      output evt_count,
`endif
      input  ena,
      input  raw_in,
      output clean_out,
      output rise_pulse,
      output fall_pulse,
      output any_change
   );
endinterface

// File: rtl/tt_input_conditioner.sv
// rtl/tt_input_conditioner.sv - per-bit synchroniser, debouncer and edge-pulse generator
// Optional bit-0 rise counter is built only when EVT_COUNT_EN is defined.
module tt_input_conditioner #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   tt_input_conditioner_if.slave bus
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] clean_q, clean_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             any_q, any_d;

   // The synchroniser runs free of ena so the metastability window is always covered.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.raw_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int b = 0; b < WIDTH; b++) begin
         cnt_d[b] = cnt_q[b];
      end
      if (bus.ena) begin
         for (int b = 0; b < WIDTH; b++) begin
            if (s[b] == clean_q[b]) begin
               cnt_d[b] = '0;
            end else if (cnt_q[b] == DB_LAST) begin
               clean_d[b] = s[b];
               cnt_d[b]   = '0;
               rise_d[b]  = s[b];
               fall_d[b]  = ~s[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
      any_d = |{rise_d, fall_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clean_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         any_q   <= 1'b0;
         for (int b = 0; b < WIDTH; b++) begin
            cnt_q[b] <= '0;
         end
      end else begin
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         any_q   <= any_d;
         for (int b = 0; b < WIDTH; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
      end
   end

   assign bus.clean_out  = clean_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.any_change = any_q;

`ifdef EVT_COUNT_EN
   logic [7:0] evt_q;

   // Clear outranks a coincident rise so software sees a clean zero.
   always_ff @(posedge clk) begin
      if (rst || bus.evt_clear) begin
         evt_q <= '0;
      end else if (rise_q[0]) begin
         evt_q <= evt_q + 8'd1;
      end
   end

   assign bus.evt_count = evt_q;
`endif

endmodule
